// File: rtl/cy_fifo_pkg.sv
// rtl/cy_fifo_pkg.sv - shared constants for the FX2LP slave-FIFO model
package cy_fifo_pkg;

  // faddr endpoint codes; only EP2 and EP6 are populated
  localparam logic [1:0] FADDR_EP2 = 2'b00;
  localparam logic [1:0] FADDR_EP4 = 2'b01;
  localparam logic [1:0] FADDR_EP6 = 2'b10;
  localparam logic [1:0] FADDR_EP8 = 2'b11;

  localparam int DATA_W = 16;

  // bit positions of the active-low flags inside the flag register
  localparam int FLAG_A = 0;  // EP6 empty
  localparam int FLAG_B = 1;  // EP6 full
  localparam int FLAG_C = 2;  // EP2 empty
  localparam int FLAG_D = 3;  // EP2 full

endpackage

// File: rtl/cy_ep_fifo.sv
// rtl/cy_ep_fifo.sv - endpoint FIFO with held head word and last-word tag port
module cy_ep_fifo #(
  parameter int W  = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          tag_we,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic [AW:0]   count_nxt
);

  localparam logic [AW:0]   DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   ONE_C = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ONE_P = {{(AW-1){1'b0}}, 1'b1};

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  last_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // when empty the head keeps showing the last word popped (0 after reset)
  assign head    = empty ? last_q : mem[rd_ptr];

  // storage array, left unreset so it can map onto RAM; the tag bit of the
  // most recently written word can be set after the fact
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
    if (tag_we && !empty) mem[wr_ptr - ONE_P][W-1] <= 1'b1;
  end

  // next fill level; simultaneous push and pop leave it unchanged
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) count_nxt = count + ONE_C;
    else if (do_pop && !do_push) count_nxt = count - ONE_C;
  end

  // pointers, fill level and held head word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE_P;
      if (do_pop) begin
        rd_ptr <= rd_ptr + ONE_P;
        last_q <= mem[rd_ptr];
      end
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/cy_slave_fifo.sv
// rtl/cy_slave_fifo.sv - FX2LP slave-FIFO responder with EP2 OUT and EP6 IN endpoints
module cy_slave_fifo
  import cy_fifo_pkg::*;
#(
  parameter int EP_AW     = 8,
  parameter int PKT_WORDS = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ifclk,
  input  logic              sloe,
  input  logic              slrd,
  input  logic              slwr,
  input  logic              pktend,
  input  logic [1:0]        faddr,
  input  logic [DATA_W-1:0] fdata_in,
  output logic [DATA_W-1:0] fdata_out,
  output logic              fdata_oe,
  output logic              flaga,
  output logic              flagb,
  output logic              flagc,
  output logic              flagd,
  input  logic              h2d_valid,
  input  logic [DATA_W-1:0] h2d_data,
  output logic              h2d_ready,
  output logic              d2h_valid,
  output logic [DATA_W-1:0] d2h_data,
  output logic              d2h_last,
  input  logic              d2h_ready,
  output logic [EP_AW:0]    ep2_count,
  output logic [EP_AW:0]    ep6_count,
  output logic              err_ovf,
  output logic              err_proto
);

  localparam logic [EP_AW:0] DEPTH = {1'b1, {EP_AW{1'b0}}};
  localparam logic [EP_AW:0] ONE   = {{EP_AW{1'b0}}, 1'b1};

  logic              ifclk_q;
  logic              ev;
  logic              rd_req, wr_req, end_req, collide;
  logic              sel_ep2, sel_ep6, bad_addr;
  logic              ep2_pop, ep2_empty, ep2_full;
  logic [EP_AW:0]    ep2_nxt;
  logic              ep6_wr, ep6_push, ep6_drain, ep6_empty, ep6_full;
  logic [DATA_W:0]   ep6_head;
  logic [EP_AW:0]    ep6_nxt;
  logic [EP_AW:0]    open_cnt;
  logic [EP_AW:0]    commit_cnt;
  logic              auto_commit, end_commit, commit, tag_late;
  logic [3:0]        flags_q;

  // master strobes only act on the clk cycle where ifclk has just risen
  assign ev       = ifclk & ~ifclk_q;
  assign sel_ep2  = (faddr == FADDR_EP2);
  assign sel_ep6  = (faddr == FADDR_EP6);
  assign bad_addr = (faddr == FADDR_EP4) | (faddr == FADDR_EP8);
  assign rd_req   = ev & ~slrd;
  assign wr_req   = ev & ~slwr;
  assign end_req  = ev & ~pktend;
  assign collide  = rd_req & wr_req;

  assign ep2_pop  = rd_req & ~wr_req & sel_ep2 & ~ep2_empty;
  assign ep6_wr   = wr_req & ~rd_req & sel_ep6;
  assign ep6_push = ep6_wr & ~ep6_full;

  // a packet closes either on reaching PKT_WORDS or on pktend with data open;
  // when the closing word is being pushed now it carries its own tag
  assign auto_commit = ep6_push & ((int'(open_cnt) + 1) == PKT_WORDS);
  assign end_commit  = end_req & sel_ep6 & ((open_cnt != '0) | ep6_push);
  assign commit      = auto_commit | end_commit;
  assign tag_late    = end_commit & ~ep6_push;

  // the host may only drain words that belong to committed packets
  assign d2h_valid = (commit_cnt != '0) & ~ep6_empty;
  assign ep6_drain = d2h_valid & d2h_ready;
  assign d2h_data  = ep6_head[DATA_W-1:0];
  assign d2h_last  = ep6_head[DATA_W];

  assign h2d_ready = ~ep2_full;
  assign fdata_oe  = ~sloe & sel_ep2;

  assign flaga = flags_q[FLAG_A];
  assign flagb = flags_q[FLAG_B];
  assign flagc = flags_q[FLAG_C];
  assign flagd = flags_q[FLAG_D];

  cy_ep_fifo #(.W(DATA_W), .AW(EP_AW)) u_ep2 (
    .clk       (clk),
    .rstn      (rstn),
    .push      (h2d_valid & h2d_ready),
    .push_data (h2d_data),
    .pop       (ep2_pop),
    .tag_we    (1'b0),
    .head      (fdata_out),
    .empty     (ep2_empty),
    .full      (ep2_full),
    .count     (ep2_count),
    .count_nxt (ep2_nxt)
  );

  cy_ep_fifo #(.W(DATA_W + 1), .AW(EP_AW)) u_ep6 (
    .clk       (clk),
    .rstn      (rstn),
    .push      (ep6_push),
    .push_data ({commit, fdata_in}),
    .pop       (ep6_drain),
    .tag_we    (tag_late),
    .head      (ep6_head),
    .empty     (ep6_empty),
    .full      (ep6_full),
    .count     (ep6_count),
    .count_nxt (ep6_nxt)
  );

  // ifclk edge detector, open-packet length and committed-word count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifclk_q    <= 1'b1;
      open_cnt   <= '0;
      commit_cnt <= '0;
    end else begin
      ifclk_q <= ifclk;
      if (commit) open_cnt <= '0;
      else if (ep6_push) open_cnt <= open_cnt + ONE;
      commit_cnt <= commit_cnt
                  + (commit ? open_cnt + {{EP_AW{1'b0}}, ep6_push} : '0)
                  - {{EP_AW{1'b0}}, ep6_drain};
    end
  end

  // flags registered from post-update fill levels so they hold steady for the master
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flags_q         <= '0;
      flags_q[FLAG_B] <= 1'b1;
      flags_q[FLAG_D] <= 1'b1;
    end else begin
      flags_q[FLAG_A] <= (ep6_nxt != '0);
      flags_q[FLAG_B] <= (ep6_nxt != DEPTH);
      flags_q[FLAG_C] <= (ep2_nxt != '0);
      flags_q[FLAG_D] <= (ep2_nxt != DEPTH);
    end
  end

  // sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_ovf   <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      if (ep6_wr && ep6_full) err_ovf <= 1'b1;
      if (collide || (bad_addr && (rd_req || wr_req || end_req))) err_proto <= 1'b1;
    end
  end

endmodule
